// File: rtl/window_line_buffer.sv
// Sliding KxK window over a raster-ordered IFM stream: a (K-1) line + K pixel
// shift register, position/stride tracking and a flag for each window that lies fully inside the frame.
module window_line_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 14,
  parameter int KERNAL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int OFM_SIZE    = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1,
  parameter int FIFO_SIZE   = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE,
  parameter int COORD_BITS  = $clog2(IFM_SIZE)
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            fifo_enable,
  input  logic [DATA_WIDTH-1:0]                           fifo_data_in,
  input  logic                                            flush,
  output logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0]   window_data_out,
  output logic                                            window_valid,
  output logic [$clog2(OFM_SIZE)-1:0]                     window_row,
  output logic [$clog2(OFM_SIZE)-1:0]                     window_col,
  output logic                                            frame_done
);

  localparam int K          = KERNAL_SIZE;
  localparam int PHASE_BITS = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [DATA_WIDTH-1:0] fifo_q [FIFO_SIZE];
  logic [COORD_BITS-1:0] pix_col, pix_row;
  logic [COORD_BITS-1:0] next_col, next_row;
  logic [PHASE_BITS-1:0] col_phase, row_phase;
  logic                  push, col_last, row_last, in_win;

  // Phase of the next coordinate: pinned to 0 up to K-1 so the first window lands on phase 0.
  function automatic logic [PHASE_BITS-1:0] next_phase(input logic [COORD_BITS-1:0] next_pos,
                                                       input logic [PHASE_BITS-1:0] phase);
    if (next_pos <= COORD_BITS'(K - 1))
      return '0;
    else if (phase == PHASE_BITS'(STRIDE - 1))
      return '0;
    else
      return phase + 1'b1;
  endfunction

  always_comb begin
    push     = fifo_enable && !flush;
    col_last = (pix_col == COORD_BITS'(IFM_SIZE - 1));
    row_last = (pix_row == COORD_BITS'(IFM_SIZE - 1));
    next_col = col_last ? '0 : pix_col + 1'b1;
    next_row = row_last ? '0 : pix_row + 1'b1;
    in_win   = (pix_row >= COORD_BITS'(K - 1)) && (pix_col >= COORD_BITS'(K - 1)) &&
               (row_phase == '0) && (col_phase == '0);
  end

  // Stage p0: pixel shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_SIZE; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[0] <= fifo_data_in;
      for (int i = 1; i < FIFO_SIZE; i++) fifo_q[i] <= fifo_q[i-1];
    end
  end

  // Stage p0: position, stride phase and window flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_col      <= '0;
      pix_row      <= '0;
      col_phase    <= '0;
      row_phase    <= '0;
      window_valid <= 1'b0;
      window_row   <= '0;
      window_col   <= '0;
      frame_done   <= 1'b0;
    end else if (flush) begin
      pix_col      <= '0;
      pix_row      <= '0;
      col_phase    <= '0;
      row_phase    <= '0;
      window_valid <= 1'b0;
      window_row   <= '0;
      window_col   <= '0;
      frame_done   <= 1'b0;
    end else if (fifo_enable) begin
      pix_col      <= next_col;
      col_phase    <= next_phase(next_col, col_phase);
      if (col_last) begin
        pix_row    <= next_row;
        row_phase  <= next_phase(next_row, row_phase);
      end
      window_valid <= in_win;
      frame_done   <= col_last && row_last;
      if (in_win) begin
        if (pix_col == COORD_BITS'(K - 1)) begin
          window_col <= '0;
          window_row <= (pix_row == COORD_BITS'(K - 1)) ? '0 : window_row + 1'b1;
        end else begin
          window_col <= window_col + 1'b1;
        end
      end
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end
  end

  // Element r*K+c taps the shift register; r=0 is the oldest row, c=0 the leftmost column.
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign window_data_out[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = fifo_q[(K-1-r)*IFM_SIZE + (K-1-c)];
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer: a 14/5/1 and a 13/5/2 instance share one stimulus
// stream and are compared every cycle against a pixel-history reference model.
module tb_window_line_buffer;

  localparam int DW = 32;
  localparam int K  = 5;
  localparam int WB = K * K * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_enable;
  logic          flush;
  logic [DW-1:0] fifo_data_in;
  logic [WB-1:0] win0, win1;
  logic          v0, v1, d0, d1;
  logic [3:0]    r0, c0;
  logic [2:0]    r1, c1;

  always #5 clk = ~clk;

  window_line_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(14), .KERNAL_SIZE(K), .STRIDE(1)) dut0 (
    .clk(clk), .reset(reset), .fifo_enable(fifo_enable), .fifo_data_in(fifo_data_in),
    .flush(flush), .window_data_out(win0), .window_valid(v0), .window_row(r0),
    .window_col(c0), .frame_done(d0));

  window_line_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(13), .KERNAL_SIZE(K), .STRIDE(2)) dut1 (
    .clk(clk), .reset(reset), .fifo_enable(fifo_enable), .fifo_data_in(fifo_data_in),
    .flush(flush), .window_data_out(win1), .window_valid(v1), .window_row(r1),
    .window_col(c1), .frame_done(d1));

  int unsigned hist[$];
  int          n_pix [2];
  logic        exp_v [2];
  logic        exp_d [2];
  int          exp_r [2];
  int          exp_c [2];
  int          pulse_cnt [2];
  int          done_cnt [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_val(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ifm_of(input int i);
    return (i == 0) ? 14 : 13;
  endfunction

  function automatic int stride_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  // Window straight from the pushed-pixel history: element (r,c) is the pixel
  // pushed (K-1-r) lines and (K-1-c) pixels before the newest one.
  function automatic logic [WB-1:0] model_window(input int ifm);
    logic [WB-1:0] w;
    int idx;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        idx = (K-1-r)*ifm + (K-1-c);
        if (idx < hist.size()) w[(r*K+c)*DW +: DW] = hist[hist.size()-1-idx];
      end
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      n_pix[i] = 0; exp_v[i] = 1'b0; exp_d[i] = 1'b0; exp_r[i] = 0; exp_c[i] = 0;
    end
  endtask

  task automatic model_push(input int unsigned d);
    int ifm, s, row, col;
    hist.push_back(d);
    if (hist.size() > 128) void'(hist.pop_front());
    for (int i = 0; i < 2; i++) begin
      ifm = ifm_of(i); s = stride_of(i);
      row = n_pix[i] / ifm; col = n_pix[i] % ifm;
      exp_v[i] = (row >= K-1) && (col >= K-1) && ((row-(K-1)) % s == 0) && ((col-(K-1)) % s == 0);
      if (exp_v[i]) begin
        exp_r[i] = (row-(K-1)) / s;
        exp_c[i] = (col-(K-1)) / s;
      end
      exp_d[i] = (n_pix[i] == ifm*ifm-1);
      n_pix[i] = (n_pix[i] + 1) % (ifm*ifm);
    end
  endtask

  task automatic compare_all();
    check_val("valid0", WB'(v0), WB'(exp_v[0]));
    check_val("done0",  WB'(d0), WB'(exp_d[0]));
    check_val("row0",   WB'(r0), WB'(exp_r[0]));
    check_val("col0",   WB'(c0), WB'(exp_c[0]));
    check_val("win0",   win0,    model_window(14));
    check_val("valid1", WB'(v1), WB'(exp_v[1]));
    check_val("done1",  WB'(d1), WB'(exp_d[1]));
    check_val("row1",   WB'(r1), WB'(exp_r[1]));
    check_val("col1",   WB'(c1), WB'(exp_c[1]));
    check_val("win1",   win1,    model_window(13));
    if (v0) pulse_cnt[0]++;
    if (v1) pulse_cnt[1]++;
    if (d0) done_cnt[0]++;
    if (d1) done_cnt[1]++;
  endtask

  task automatic step(input logic en, input logic fl, input logic [DW-1:0] d);
    fifo_enable = en; flush = fl; fifo_data_in = d;
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else if (en) begin
      model_push(d);
    end else begin
      exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_d[0] = 1'b0; exp_d[1] = 1'b0;
    end
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_win0"}, win0, '0);
    check_val({tag, "_win1"}, win1, '0);
    check_val({tag, "_v0"}, WB'(v0), '0);
    check_val({tag, "_v1"}, WB'(v1), '0);
    check_val({tag, "_d0"}, WB'(d0), '0);
    check_val({tag, "_d1"}, WB'(d1), '0);
    check_val({tag, "_rc0"}, WB'({r0, c0}), '0);
    check_val({tag, "_rc1"}, WB'({r1, c1}), '0);
  endtask

  // Reset asserted between edges with a push pending; clears both DUTs immediately.
  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1; fifo_enable = 1'b1; flush = 1'b0; fifo_data_in = 32'hdead_beef;
    #1;
    check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    reset = 1'b0; fifo_enable = 1'b0;
    hist.delete();
    model_clear();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      pulse_cnt[i] = 0; done_cnt[i] = 0;
    end
  endtask

  task automatic run_frame(input int unsigned base, input int count, input logic toggle);
    for (int i = 1; i <= count; i++) begin
      step(1'b1, 1'b0, base + i);
      if (toggle) step(1'b0, 1'b0, $urandom);
    end
  endtask

  initial begin
    reset = 1'b0; fifo_enable = 1'b0; flush = 1'b0; fifo_data_in = '0;
    hist.delete();
    model_clear();
    clear_counts();

    hard_reset();
    step(1'b0, 1'b0, $urandom);
    step(1'b0, 1'b0, $urandom);

    hard_reset();
    clear_counts();
    run_frame(0, 196, 1'b0);
    check_val("cont_pulses", WB'(pulse_cnt[0]), WB'(100));
    check_val("cont_done",   WB'(done_cnt[0]),  WB'(1));

    hard_reset();
    clear_counts();
    run_frame(0, 169, 1'b0);
    check_val("s2_pulses", WB'(pulse_cnt[1]), WB'(25));
    check_val("s2_done",   WB'(done_cnt[1]),  WB'(1));

    hard_reset();
    clear_counts();
    run_frame(0, 196, 1'b1);
    check_val("tog_pulses", WB'(pulse_cnt[0]), WB'(100));

    hard_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, 32'h5555_aaaa);
    clear_counts();
    run_frame(0, 196, 1'b0);
    check_val("flush_pulses", WB'(pulse_cnt[0]), WB'(100));

    hard_reset();
    clear_counts();
    run_frame(0, 196, 1'b0);
    run_frame(1000, 196, 1'b0);
    check_val("b2b_pulses", WB'(pulse_cnt[0]), WB'(200));
    check_val("b2b_done",   WB'(done_cnt[0]),  WB'(2));

    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) hard_reset();
      step(($urandom % 4) != 0, ($urandom % 150) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Parametrised sliding-window line buffer for the convolution layers.
- Accepts a raster-ordered IFM stream, one pixel per enabled cycle, and presents the full KERNAL_SIZE x KERNAL_SIZE window as one flattened bus.
- Tracks row/column position and flags only windows that are geometrically valid for the programmed stride.
- Sits between the IFM memory reader and the MAC array; successor to the fixed 5x5, 25-port window FIFO.

Parameters:
- DATA_WIDTH, 32, pixel width in bits.
- IFM_SIZE, 14, IFM width and height in pixels.
- KERNAL_SIZE, 5, window edge K (any value >= 2).
- STRIDE, 1, window step in both directions; (IFM_SIZE-KERNAL_SIZE) % STRIDE must equal 0.
- OFM_SIZE, (IFM_SIZE-KERNAL_SIZE)/STRIDE+1, derived; output map edge.
- FIFO_SIZE, (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE, derived; shift-register depth.
- COORD_BITS, $clog2(IFM_SIZE), derived; counter width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- fifo_enable  input  1  push strobe; fifo_data_in accepted on this edge.
- fifo_data_in  input  DATA_WIDTH  incoming pixel.
- flush  input  1  synchronous frame restart; clears counters only.
- window_data_out  output  K*K*DATA_WIDTH  flattened window.
- window_valid  output  1  one-cycle pulse: window_data_out is a valid window.
- window_row  output  $clog2(OFM_SIZE)  output-map row of the flagged window.
- window_col  output  $clog2(OFM_SIZE)  output-map column of the flagged window.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is pushed.

Behaviour:
- Reset: all FIFO entries, counters, window_valid, window_row, window_col and frame_done are 0. window_data_out is therefore all zeros.
- Push (fifo_enable=1, flush=0):
  - FIFO[0] <= fifo_data_in and FIFO[i+1] <= FIFO[i].
  - The entry at FIFO_SIZE-1 is discarded.
  - Without a push, the FIFO holds its contents.
- Window mapping: element k = r*K + c, with r,c in 0..K-1 (r=0 is the oldest row, c=0 the leftmost column).
  - Element k is FIFO[(K-1-r)*IFM_SIZE + (K-1-c)].
  - It drives window_data_out[k*DATA_WIDTH +: DATA_WIDTH].
  - The mapping is combinational from the FIFO registers.
- Position counters: pix_col and pix_row hold the coordinates of the pixel being pushed.
  - Each push increments pix_col.
  - At IFM_SIZE-1, pix_col wraps to 0 and pix_row increments.
  - At (IFM_SIZE-1, IFM_SIZE-1) both wrap to 0.
- Stride tracking: phase counters use no modulo operator.
  - col_phase resets at each row start and at pix_col = K-1, and counts 0..STRIDE-1 thereafter.
  - row_phase behaves the same way, keyed on pix_row.
- window_valid: registered on the push edge. Value = (pix_row >= K-1) && (pix_col >= K-1) && row_phase==0 && col_phase==0, evaluated for the incoming pixel.
  - In the following cycle it is coincident with the updated window_data_out.
  - Without a further push it returns to 0; window data stays stable.
- window_row and window_col: registered with window_valid, set to (pix_row-(K-1))/STRIDE and (pix_col-(K-1))/STRIDE. Implemented as incrementing counters; they hold their value between pulses.
- frame_done: registered pulse on the push of pixel (IFM_SIZE-1, IFM_SIZE-1); coincides with the last window_valid.
- Back-to-back frames need no flush: the first valid window of a new frame contains only new-frame pixels.
- flush:
  - Clears pix_row, pix_col, the phase counters, window_row and window_col. window_valid and frame_done are forced to 0 next cycle.
  - FIFO data is not cleared.
  - flush and fifo_enable in the same cycle: flush wins and the pixel is dropped.
- Reset mid-frame: immediate clear of everything; the next push is treated as pixel (0,0).

Test Plan:
- Reset asserted with fifo_enable active → window_data_out all zero, window_valid=frame_done=0, both while asserted and after release.
- Defaults (14/5/1), push values 1..196 back-to-back:
  - First window_valid follows push 61: element0=1, element5=15, element24=61, window_row=window_col=0.
  - 100 pulses in total.
  - Last pulse has window_row=window_col=9 and coincides with frame_done.
- IFM_SIZE=13, K=5, STRIDE=2, push 1..169:
  - Pulses at pixels with row,col ∈ {4,6,8,10,12}, 25 in total; first after push 57 with element24=57.
  - Second pulse after push 59 with window_col=1.
- Defaults with fifo_enable toggled 1/0 every cycle → same 100 windows and values as the continuous run; every valid is 1 cycle wide; data stable in idle cycles.
- Push 100 pixels, assert flush together with fifo_enable, then push 1..196 → the flush-cycle pixel is dropped; first valid after the 61st post-flush push with element0=1; 100 pulses.
- Two consecutive frames without flush (1..196 then 1001..1196) → second frame's first window element0=1001, element24=1061; second frame_done observed.
